// File: rtl/enc_pkg.sv
// Shared constants, derived-width helpers and FSM state type for the streaming
// feature bundler.
package enc_pkg;

  localparam int FEATURE_COUNT    = 617;
  localparam int ENCODING_BIT_THR = 308;

  function automatic int calc_cnt_w(input int fc);
    return $clog2(fc + 1);
  endfunction

  function automatic int calc_beats(input int fc, input int cw);
    return (fc + cw - 1) / cw;
  endfunction

  // Number of meaningful feature bits in the final beat of a vector.
  function automatic int calc_last_w(input int fc, input int cw);
    return fc - (calc_beats(fc, cw) - 1) * cw;
  endfunction

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } bund_state_t;

endpackage

// File: rtl/enc_bundler_stream_if.sv
// Beat input and result output bus of the streaming bundler, plus the
// per-vector threshold controls that travel with the first beat.
interface enc_bundler_stream_if #(
  parameter int LANES   = 8,
  parameter int CHUNK_W = 64,
  parameter int CNT_W   = enc_pkg::calc_cnt_w(enc_pkg::FEATURE_COUNT)
);

  // Both sides: a transfer happens on a rising edge where valid && ready;
  // the producer keeps data stable while valid is high and ready is low.
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*CHUNK_W-1:0] in_bits;
  logic [CNT_W-1:0]         thr;
  logic                     maj_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES-1:0]         out_bits;

  modport master (
    output in_valid, in_bits, thr, maj_mode, out_ready,
    input  in_ready, out_valid, out_bits
  );

  modport slave (
    input  in_valid, in_bits, thr, maj_mode, out_ready,
    output in_ready, out_valid, out_bits
  );

endinterface

// File: rtl/enc_popcount_tree.sv
// Balanced binary adder tree counting set bits of a W-bit word; an odd node at
// any level is carried up unchanged. Optional output register.
module enc_popcount_tree #(
  parameter int W       = 64,
  parameter bit OUT_REG = 1'b1,
  localparam int OW     = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  bits,
  output logic [OW-1:0] count
);
  import enc_pkg::*;

  localparam int LV = $clog2(W);

  logic [OW-1:0] node [LV+1][W];

  function automatic int lvl_n(input int k);
    return (W + (1 << k) - 1) >> k;
  endfunction

  always_comb begin
    for (int k = 0; k <= LV; k++) begin
      for (int i = 0; i < W; i++) begin
        node[k][i] = '0;
      end
    end
    for (int i = 0; i < W; i++) begin
      node[0][i] = OW'(bits[i]);
    end
    for (int k = 0; k < LV; k++) begin
      for (int j = 0; j < (W + 1) / 2; j++) begin
        if (2 * j + 1 < lvl_n(k)) begin
          node[k+1][j] = node[k][2*j] + node[k][2*j+1];
        end else if (2 * j < lvl_n(k)) begin
          node[k+1][j] = node[k][2*j];
        end
      end
    end
  end

  if (OUT_REG) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else     count <= node[LV][0];
    end
  end else begin : g_comb
    assign count = node[LV][0];
  end

endmodule

// File: rtl/enc_bundler_stream.sv
// Multi-lane streaming bundler: accumulates per-lane popcounts over BEATS input
// beats and emits one thresholded hypervector bit per lane.
module enc_bundler_stream #(
  parameter int FEATURE_COUNT = enc_pkg::FEATURE_COUNT,
  parameter int CHUNK_W       = 64,
  parameter int LANES         = 8,
  parameter int TREE_PIPE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  enc_bundler_stream_if.slave   bus,
  output enc_pkg::bund_state_t  state_dbg
);
  import enc_pkg::*;

  localparam int CNT_W  = calc_cnt_w(FEATURE_COUNT);
  localparam int BEATS  = calc_beats(FEATURE_COUNT, CHUNK_W);
  localparam int LAST_W = calc_last_w(FEATURE_COUNT, CHUNK_W);
  localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PC_W   = $clog2(CHUNK_W + 1);

  localparam logic [CHUNK_W-1:0] LAST_MASK  = {CHUNK_W{1'b1}} >> (CHUNK_W - LAST_W);
  localparam logic [CNT_W-1:0]   MAJ_THR    = CNT_W'(FEATURE_COUNT >> 1);
  localparam logic [BC_W-1:0]    LAST_BEAT  = BC_W'(BEATS - 1);
  localparam logic               DRAIN_LAST = (TREE_PIPE != 0);

  bund_state_t      state_q, state_d;
  logic [BC_W-1:0]  beat_cnt;
  logic             drain_cnt;
  logic [CNT_W-1:0] thr_q;
  logic [LANES-1:0] out_bits_q;
  logic [LANES-1:0] cmp;
  logic             accept, first_beat, last_beat;
  logic             pc_vld, pc_first;
  logic [PC_W-1:0]  pc  [LANES];
  logic [CNT_W-1:0] acc [LANES];

  assign bus.in_ready  = (state_q == ACCUM) && !rst;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_bits  = out_bits_q;
  assign state_dbg     = state_q;

  // A beat arriving together with abort is dropped.
  assign accept     = bus.in_valid && bus.in_ready && !abort;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == LAST_BEAT);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CHUNK_W-1:0] chunk;
    // Padding bits of the final beat never reach the count.
    assign chunk = bus.in_bits[l*CHUNK_W +: CHUNK_W] & (last_beat ? LAST_MASK : {CHUNK_W{1'b1}});

    enc_popcount_tree #(.W(CHUNK_W), .OUT_REG(TREE_PIPE != 0)) u_pc (
      .clk   (clk),
      .rst   (rst),
      .bits  (chunk),
      .count (pc[l])
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc[l] <= '0;
      end else if (pc_vld && !abort) begin
        acc[l] <= pc_first ? CNT_W'(pc[l]) : acc[l] + CNT_W'(pc[l]);
      end
    end

    assign cmp[l] = (acc[l] > thr_q);
  end

  if (TREE_PIPE != 0) begin : g_pc_pipe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pc_vld   <= 1'b0;
        pc_first <= 1'b0;
      end else begin
        pc_vld   <= accept;
        pc_first <= first_beat;
      end
    end
  end else begin : g_pc_comb
    assign pc_vld   = accept;
    assign pc_first = first_beat;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_beat)              state_d = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST)          state_d = HOLD;
      HOLD:    if (bus.out_valid && bus.out_ready)   state_d = ACCUM;
      default:                                       state_d = ACCUM;
    endcase
    if (abort) state_d = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt   <= '0;
      drain_cnt  <= 1'b0;
      thr_q      <= '0;
      out_bits_q <= '0;
    end else if (abort) begin
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      // Threshold is frozen for the whole vector at its first beat.
      if (accept && first_beat) thr_q <= bus.maj_mode ? MAJ_THR : bus.thr;
      drain_cnt <= (state_q == DRAIN) ? drain_cnt + 1'b1 : 1'b0;
      if (state_q == DRAIN && state_d == HOLD) out_bits_q <= cmp;
    end
  end

endmodule
